// File: rtl/bus_slave_decoder_if.sv
// Master-side bus bundle between the granted master and the slave address decoder.
// The decoder connects through the slave modport; the master/bench side uses master.
interface bus_slave_decoder_if #(
  parameter int ADDR_W = 8
);
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        s_sel;
  logic [3:0]        rd_sel;
  logic              rd_valid;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output m_req, m_wr, m_addr,
    input  s_sel, rd_sel, rd_valid, err, err_cnt, err_addr
  );

  modport slave (
    input  m_req, m_wr, m_addr,
    output s_sel, rd_sel, rd_valid, err, err_cnt, err_addr
  );
endinterface

// File: rtl/bus_slave_decoder.sv
// Decodes the master address to one-hot chip selects (0 cycles) and registers the read-return select / unmapped-access error (1 cycle).
// No backpressure: a new request may be accepted every cycle, and each one fully determines the next registered state.
module bus_slave_decoder #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] S0_BASE  = 8'h00,
  parameter logic [ADDR_W-1:0] S1_BASE  = 8'h20,
  parameter logic [ADDR_W-1:0] S2_BASE  = 8'h40,
  parameter logic [ADDR_W-1:0] S3_BASE  = 8'h60,
  parameter int                SLV_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  bus_slave_decoder_if.slave  bus
);

  // State bits double as the registered rd_valid / err outputs.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RDATA = 2'b01,
    ERR   = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] BASES [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
  localparam logic [ADDR_W:0]   SIZE_X    = (ADDR_W+1)'(SLV_SIZE);

  state_t            r_state;
  logic [3:0]        r_rd_sel;
  logic [7:0]        r_err_cnt;
  logic [ADDR_W-1:0] r_err_addr;

  logic [ADDR_W:0]   w_addr_x;
  logic [3:0]        w_hit;
  logic [3:0]        w_sel;
  logic              w_rd_hit;
  logic              w_unmapped;

  assign w_addr_x = {1'b0, bus.m_addr};

  // Upper bound kept one bit wider so a window ending at 2^ADDR_W does not wrap.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < 4; k++) begin
      w_hit[3-k] = (w_addr_x >= {1'b0, BASES[k]}) &&
                   (w_addr_x <  ({1'b0, BASES[k]} + SIZE_X));
    end
  end

  always_comb begin
    w_sel = '0;
    if (bus.m_req) begin
      if      (w_hit[3]) w_sel = 4'b1000;
      else if (w_hit[2]) w_sel = 4'b0100;
      else if (w_hit[1]) w_sel = 4'b0010;
      else if (w_hit[0]) w_sel = 4'b0001;
    end
  end

  assign w_rd_hit   = (|w_sel) && !bus.m_wr;
  assign w_unmapped = bus.m_req && !(|w_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rd_sel   <= '0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else begin
      r_rd_sel <= '0;
      if (w_rd_hit) begin
        r_state  <= RDATA;
        r_rd_sel <= w_sel;
      end else if (w_unmapped) begin
        r_state    <= ERR;
        r_err_addr <= bus.m_addr;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.s_sel    = w_sel;
  assign bus.rd_sel   = r_rd_sel;
  assign bus.rd_valid = r_state[0];
  assign bus.err      = r_state[1];
  assign bus.err_cnt  = r_err_cnt;
  assign bus.err_addr = r_err_addr;

endmodule

// File: tb/tb_bus_slave_decoder.sv
// Bench for bus_slave_decoder: directed vector table, reset corner cases and random traffic against a window-lookup model.
module tb_bus_slave_decoder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_slave_decoder_if #(.ADDR_W(8)) bus ();
  bus_slave_decoder_if #(.ADDR_W(8)) bus2 ();

  bus_slave_decoder #(.ADDR_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  bus_slave_decoder #(.ADDR_W(8), .S1_BASE(8'h00)) dut_pri (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  typedef struct {
    logic       req;
    logic       wr;
    logic [7:0] addr;
    logic [3:0] s_sel;
    logic [3:0] rd_sel;
    logic       rd_valid;
    logic       err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int         bases [4] = '{0, 32, 64, 96};
  logic [3:0] m_rd_sel;
  logic       m_rd_valid;
  logic       m_err;
  int         m_cnt;
  logic [7:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_sel(input logic req, input logic [7:0] a);
    logic [3:0] one;
    one = 4'b1000;
    if (!req) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (int'(a) >= bases[k] && int'(a) < bases[k] + 32) return one >> k;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_rd_sel = 0; m_rd_valid = 0; m_err = 0; m_cnt = 0; m_eaddr = 0;
  endtask

  task automatic model_step(input logic req, input logic wr, input logic [7:0] a);
    logic [3:0] s;
    s = ref_sel(req, a);
    m_rd_sel   = (req && !wr && s != 0) ? s : 4'b0000;
    m_rd_valid = (m_rd_sel != 0);
    m_err      = req && (s == 0);
    if (m_err) begin
      m_eaddr = a;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " rd_sel"},   32'(bus.rd_sel),   32'(m_rd_sel));
    chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(m_rd_valid));
    chk({tag, " err"},      32'(bus.err),      32'(m_err));
    chk({tag, " err_cnt"},  32'(bus.err_cnt),  32'(m_cnt));
    chk({tag, " err_addr"}, 32'(bus.err_addr), 32'(m_eaddr));
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic req, input logic wr, input logic [7:0] a,
                       input bit use_v, input vec_t v, input string tag);
    bus.m_req = req; bus.m_wr = wr; bus.m_addr = a;
    #1;
    chk({tag, " s_sel"}, 32'(bus.s_sel), 32'(ref_sel(req, a)));
    if (use_v) chk({tag, " tbl s_sel"}, 32'(bus.s_sel), 32'(v.s_sel));
    @(posedge clk);
    model_step(req, wr, a);
    @(negedge clk);
    check_regs(tag);
    if (use_v) begin
      chk({tag, " tbl rd_sel"},   32'(bus.rd_sel),   32'(v.rd_sel));
      chk({tag, " tbl rd_valid"}, 32'(bus.rd_valid), 32'(v.rd_valid));
      chk({tag, " tbl err"},      32'(bus.err),      32'(v.err));
    end
  endtask

  vec_t tbl [14];
  vec_t nov;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h05, 4'b1000, 4'b1000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h25, 4'b0100, 4'b0100, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h45, 4'b0010, 4'b0010, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h65, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h30, 4'b0100, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h9C, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'hF0, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h1F, 4'b1000, 4'b1000, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h20, 4'b0100, 4'b0100, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h7F, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h80, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};
    nov     = '{1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0};

    reset_n = 1'b0;
    bus.m_req = 0;  bus.m_wr = 0;  bus.m_addr = 0;
    bus2.m_req = 0; bus2.m_wr = 0; bus2.m_addr = 0;
    model_reset();
    #2;
    check_regs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, nov, "idle");

    // Mid-cycle reset while err and then rd_valid are pending.
    cycle(1'b1, 1'b0, 8'h9C, 1'b0, nov, "pre_rst_err");
    bus.m_req = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_regs("rst_in_err");
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h45, 1'b0, nov, "pre_rst_rd");
    bus.m_req = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_regs("rst_in_rd");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++)
      cycle(tbl[i].req, tbl[i].wr, tbl[i].addr, 1'b1, tbl[i], $sformatf("vec%0d", i));
    chk("unmapped err_addr", 32'(bus.err_addr), 32'h80);

    bus2.m_req = 1; bus2.m_wr = 0; bus2.m_addr = 8'h05;
    #1 chk("prio s_sel 05", 32'(bus2.s_sel), 32'b1000);
    bus2.m_addr = 8'h25;
    #1 chk("prio s_sel 25", 32'(bus2.s_sel), 32'b0000);
    bus2.m_addr = 8'h45;
    #1 chk("prio s_sel 45", 32'(bus2.s_sel), 32'b0010);
    bus2.m_req = 0;
    @(negedge clk);
    model_step(1'b1, 1'b0, 8'h45);
    model_step(1'b0, 1'b0, 8'h00);
    check_regs("after_prio");

    for (int i = 0; i < 400; i++) begin
      logic       rq;
      logic       w;
      logic [7:0] a;
      rq = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      cycle(rq, w, a, 1'b0, nov, "rand");
    end

    for (int i = 0; i < 260; i++) begin
      logic [7:0] a;
      a = 8'h80 | 8'($urandom_range(0, 127));
      cycle(1'b1, 1'($urandom_range(0, 1)), a, 1'b0, nov, "sat");
    end
    chk("sat err_cnt", 32'(bus.err_cnt), 32'hFF);
    cycle(1'b1, 1'b0, 8'hC3, 1'b0, nov, "sat_hold");
    chk("sat hold err_cnt", 32'(bus.err_cnt), 32'hFF);
    chk("sat hold err_addr", 32'(bus.err_addr), 32'hC3);

    // Mapped read whose completion edge is swallowed by reset.
    bus.m_req = 1; bus.m_wr = 0; bus.m_addr = 8'h05;
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("rst_rd err_cnt", 32'(bus.err_cnt), 32'h0);
    @(posedge clk);
    #1 chk("rst_rd rd_valid edge", 32'(bus.rd_valid), 32'h0);
    @(negedge clk);
    chk("rst_rd rd_valid neg", 32'(bus.rd_valid), 32'h0);
    bus.m_req = 0;
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, nov, "post_rst");
    cycle(1'b1, 1'b0, 8'h65, 1'b0, nov, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_slave_decoder.md
# bus_slave_decoder

Address decoder and read-phase select register for the shared bus. It sits on the master side of the interconnect. It decodes the granted master's address into one-hot slave chip selects. One cycle later it presents a registered one-hot select that drives the read-data return multiplexer, so returned data lines up with the slaves' one-cycle read latency. It also flags, counts and records accesses to unmapped addresses.

## Interface
- ADDR_W, 8, master address width.
- S0_BASE, 8'h00, base address of slave 0.
- S1_BASE, 8'h20, base address of slave 1.
- S2_BASE, 8'h40, base address of slave 2.
- S3_BASE, 8'h60, base address of slave 3.
- SLV_SIZE, 32, window size of each slave. Must be a power of two; each base must be aligned to it.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  1  master access request, valid for one cycle per transfer.
- m_wr  in  1  1 = write, 0 = read; qualified by m_req.
- m_addr  in  ADDR_W  master byte address; qualified by m_req.
- s_sel  out  4  combinational one-hot chip select, address phase. Bit3 = S0, bit2 = S1, bit1 = S2, bit0 = S3.
- rd_sel  out  4  registered one-hot read-data select, same bit order. 4'b0000 = idle/default source.
- rd_valid  out  1  registered; read data on the return mux is valid this cycle.
- err  out  1  registered one-cycle pulse for an unmapped access.
- err_cnt  out  8  saturating count of unmapped accesses.
- err_addr  out  ADDR_W  address of the most recent unmapped access.

## Operation
- Hit test for slave k: m_addr >= Sk_BASE && m_addr < Sk_BASE + SLV_SIZE.
  - Compute the upper bound in ADDR_W+1 bits so a window ending at 2^ADDR_W does not wrap.
- Overlapping windows resolve by fixed priority S0 > S1 > S2 > S3. s_sel is always one-hot or zero.
- s_sel = priority-encoded hit vector when m_req = 1; 4'b0000 when m_req = 0.
- Read, mapped (m_req = 1, m_wr = 0, hit): next cycle rd_sel = that cycle's s_sel and rd_valid = 1.
- Write, mapped: s_sel asserts for the cycle; rd_sel and rd_valid stay 0 next cycle.
- Unmapped request (m_req = 1, no hit, read or write):
  - s_sel = 0.
  - Next cycle: err = 1, err_addr = captured m_addr, err_cnt increments.
  - err_cnt saturates at 8'hFF.
  - rd_sel = 0 and rd_valid = 0.
- Registered state machine per cycle: IDLE (rd_valid = 0) / RDATA (rd_valid = 1) / ERR (err = 1).
  - The next state is chosen solely from the current cycle's request. Back-to-back requests are legal every cycle.
  - Any state → RDATA on a mapped read, → ERR on an unmapped request, → IDLE otherwise.
- rd_sel, rd_valid and err are mutually consistent in every cycle:
  - rd_valid = 1 ⇔ rd_sel ≠ 0.
  - err = 1 ⇒ rd_sel = 0.

## Timing
- Reset (reset_n = 0, asynchronous assert, takes effect immediately): rd_sel = 0, rd_valid = 0, err = 0, err_cnt = 0, err_addr = 0, state = IDLE.
- s_sel is combinational from m_req/m_addr. It is unaffected by reset except through its inputs.
- Reset deasserts synchronously to clk via the system reset synchronizer. The first request is sampled on the first rising edge with reset_n = 1.
- Latency:
  - s_sel: 0 cycles.
  - rd_sel/rd_valid: 1 cycle after the read request edge.
  - err/err_cnt/err_addr: 1 cycle after the request edge.
- rd_sel, rd_valid and err each last exactly one cycle per request unless the next cycle carries a new qualifying request.
- Reset asserted during RDATA or ERR clears the pending outputs at once. The interrupted read never produces rd_valid.
- err_cnt at 8'hFF with a new unmapped request:
  - err_cnt stays 8'hFF.
  - err still pulses.
  - err_addr still updates.

## Test plan
- Reset then idle: reset_n low mid-cycle → all registered outputs 0 immediately. With m_req = 0 for 10 cycles, s_sel = 0 and rd_valid = 0 throughout.
- Read sweep: reads to 8'h05, 8'h25, 8'h45, 8'h65 on consecutive cycles.
  - s_sel = 1000, 0100, 0010, 0001 in the same cycles.
  - rd_sel follows one cycle later with rd_valid = 1 for 4 cycles, then 0.
- Write to 8'h30: s_sel = 0100 that cycle; the next cycle has rd_sel = 0, rd_valid = 0, err = 0.
- Unmapped: read 8'h9C then write 8'hF0 back-to-back.
  - err pulses 2 cycles.
  - err_addr = 8'h9C, then 8'hF0.
  - err_cnt = 1, then 2.
  - rd_valid stays 0.
- Boundaries: reads at 8'h1F, 8'h20, 8'h7F, 8'h80 → rd_sel = 1000, 0100, 0001, then 0000 with err = 1.
  - Separate bench with S1_BASE = 8'h00: a read at 8'h05 gives s_sel = 1000 (priority).
- Saturation and reset mid-read:
  - 260 unmapped requests → err_cnt = 8'hFF and holds.
  - Then a mapped read with reset_n pulsed low before the next edge → rd_valid never asserts and err_cnt = 0.
